// File: rtl/cpu_types_pkg.sv
// Package: cpu_types_pkg
// Shared CPU types: machine word, fetch FSM state encoding and the default
// sequential fetch stride.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_STEP_DEFAULT = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// Module: fetch_skid_buf
// One-entry holding register for a fetched instruction and its npc, used when
// an icache hit lands while the IF/ID latch is stalled. Compiled only when
// FETCH_SKID_EN is defined.
`ifdef FETCH_SKID_EN
module fetch_skid_buf
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  i_load,
    input  logic  i_clear,
    input  word_t i_instr,
    input  word_t i_npc,
    output logic  o_valid,
    output word_t o_instr,
    output word_t o_npc
);

    logic  r_valid;
    word_t r_instr;
    word_t r_npc;

    // occupancy flag: clear wins over load so a redirect/halt never keeps a stale entry
    always_ff @(posedge CLK) begin
        if (RST || i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end
    end

    // payload capture; contents are meaningless while r_valid is low
    always_ff @(posedge CLK) begin
        if (i_load) begin
            r_instr <= i_instr;
            r_npc   <= i_npc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_npc   = r_npc;

endmodule
`endif

// File: rtl/fetch_unit.sv
// Module: fetch_unit
// Instruction-fetch stage: owns the PC, drives the icache port and the writer
// side of the IF/ID latch. Handles stalls, redirects, halt and icache misses.
// Optional build macro FETCH_SKID_EN adds a one-entry skid buffer so a hit
// that arrives during a stall is kept instead of re-read from the icache.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t       PC_RESET = 32'h0000_0000,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  ihit,
    input  word_t iload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  stall_i,
    input  logic  redirect_i,
    input  word_t redirect_pc_i,
    input  logic  halt_i,
    output word_t instr_o,
    output word_t npc_o,
    output logic  valid_o,
    output logic  flush_o
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    word_t        r_pc;
    word_t        w_pc_nxt;
    word_t        r_target;
    word_t        w_target_nxt;
    word_t        w_pc_inc;
    logic         w_skid_full;

    assign w_pc_inc = r_pc + word_t'(PC_STEP);

`ifdef FETCH_SKID_EN
    logic  w_skid_load;
    logic  w_skid_clear;
    word_t w_skid_instr;
    word_t w_skid_npc;

    fetch_skid_buf u_skid (
        .CLK     (CLK),
        .RST     (RST),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_instr (iload),
        .i_npc   (w_pc_inc),
        .o_valid (w_skid_full),
        .o_instr (w_skid_instr),
        .o_npc   (w_skid_npc)
    );
`else
    assign w_skid_full = 1'b0;
`endif

    // state and PC registers; reset abandons any outstanding miss
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= FETCH;
            r_pc    <= PC_RESET;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // redirect target parked while a miss drains
    always_ff @(posedge CLK) begin
        r_target <= w_target_nxt;
    end

    // next-state, next-PC and redirect-target selection
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_target_nxt = r_target;
`ifdef FETCH_SKID_EN
        w_skid_load  = 1'b0;
        w_skid_clear = w_skid_full && !stall_i;
`endif
        unique case (r_state)
            FETCH: begin
                if (halt_i) begin
                    w_state_nxt = HALTED;
`ifdef FETCH_SKID_EN
                    w_skid_clear = 1'b1;
`endif
                end else if (redirect_i) begin
`ifdef FETCH_SKID_EN
                    w_skid_clear = 1'b1;
`endif
                    if (ihit) begin
                        w_pc_nxt = redirect_pc_i;
                    end else begin
                        w_target_nxt = redirect_pc_i;
                        w_state_nxt  = DRAIN;
                    end
                end else if (w_skid_full) begin
                    // icache idle while the buffered instruction waits to be taken
                    w_pc_nxt = r_pc;
                end else if (stall_i) begin
`ifdef FETCH_SKID_EN
                    if (ihit) begin
                        w_skid_load = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                    end
`endif
                end else if (ihit) begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            DRAIN: begin
                if (halt_i) begin
                    w_state_nxt = HALTED;
                end else if (redirect_i) begin
                    if (ihit) begin
                        w_pc_nxt    = redirect_pc_i;
                        w_state_nxt = FETCH;
                    end else begin
                        w_target_nxt = redirect_pc_i;
                    end
                end else if (ihit) begin
                    w_pc_nxt    = r_target;
                    w_state_nxt = FETCH;
                end
            end
            HALTED: begin
                w_state_nxt = HALTED;
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    // icache port and IF/ID latch outputs
    always_comb begin
        imemREN  = 1'b0;
        imemaddr = r_pc;
        instr_o  = iload;
        npc_o    = w_pc_inc;
        valid_o  = 1'b0;
        flush_o  = 1'b0;
        if (RST) begin
            instr_o = '0;
            npc_o   = '0;
        end else begin
            unique case (r_state)
                FETCH: begin
                    imemREN = !w_skid_full;
                    flush_o = redirect_i;
`ifdef FETCH_SKID_EN
                    if (w_skid_full) begin
                        instr_o = w_skid_instr;
                        npc_o   = w_skid_npc;
                        valid_o = !stall_i && !halt_i && !redirect_i;
                    end else begin
                        valid_o = ihit && !stall_i && !halt_i && !redirect_i;
                    end
`else
                    valid_o = ihit && !stall_i && !halt_i && !redirect_i;
`endif
                end
                DRAIN: begin
                    imemREN = 1'b1;
                    flush_o = redirect_i;
                end
                default: begin
                    imemREN = 1'b0;
                end
            endcase
        end
    end

endmodule
